// File: rtl/median_window_feeder.sv
// median_window_feeder: buffers two image lines, forms the 3x3 neighbourhood
// around each interior pixel and streams it serially to a median stage,
// stalling input until the median stage acknowledges with DSO.
module median_window_feeder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IMG_W = 720
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] PIX_IN,
  input  logic             PIX_VALID,
  input  logic             SOF,
  output logic             PIX_READY,
  output logic [WIDTH-1:0] DI,
  output logic             DSI,
  input  logic             DSO
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  localparam logic [1:0] ST_ACCEPT = 2'd0;
  localparam logic [1:0] ST_SEND   = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  logic [1:0]       state, state_d;
  logic [CW-1:0]    col, col_d, col_eff;
  logic [1:0]       row, row_d, row_eff;
  // k holds the row-major index of the next window pixel to put on DI
  logic [3:0]       k, k_d;
  logic [WIDTH-1:0] di_d;
  logic             dsi_d;
  logic             ready_d;

  logic             accept;
  logic             complete;
  logic [WIDTH-1:0] top, mid;

  logic [WIDTH-1:0] lb0 [IMG_W];
  logic [WIDTH-1:0] lb1 [IMG_W];
  // Window stored row-major: index = r*3 + k
  logic [WIDTH-1:0] win [9];

  assign accept   = PIX_VALID && PIX_READY;
  assign col_eff  = SOF ? '0 : col;
  assign row_eff  = SOF ? 2'd0 : row;
  assign complete = (row_eff == 2'd2) && (col_eff >= CW'(2));
  assign top      = lb1[col_eff];
  assign mid      = lb0[col_eff];

  // Next-state, counter and output-register decode
  always_comb begin
    state_d = state;
    col_d   = col;
    row_d   = row;
    k_d     = k;
    di_d    = DI;
    dsi_d   = 1'b0;
    ready_d = 1'b0;

    if (accept) begin
      if (col_eff == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_eff == 2'd2) ? 2'd2 : row_eff + 2'd1;
      end else begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
      end
    end

    case (state)
      ST_ACCEPT: begin
        if (accept && complete) begin
          // win[1] becomes the top-left pixel once the window shifts this edge
          state_d = ST_SEND;
          di_d    = win[1];
          dsi_d   = 1'b1;
          k_d     = 4'd1;
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_SEND: begin
        if (k <= 4'd8) begin
          di_d  = win[k];
          dsi_d = 1'b1;
          k_d   = k + 4'd1;
        end else begin
          state_d = ST_WAIT;
          k_d     = 4'd0;
        end
      end
      ST_WAIT: begin
        if (DSO) begin
          state_d = ST_ACCEPT;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_ACCEPT;
      end
    endcase
  end

  // State, counters and registered outputs with synchronous reset
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= ST_ACCEPT;
      col       <= '0;
      row       <= 2'd0;
      k         <= 4'd0;
      DI        <= '0;
      DSI       <= 1'b0;
      PIX_READY <= 1'b0;
    end else begin
      state     <= state_d;
      col       <= col_d;
      row       <= row_d;
      k         <= k_d;
      DI        <= di_d;
      DSI       <= dsi_d;
      PIX_READY <= ready_d;
    end
  end

  // Line buffers and window shift on every accepted pixel (never cleared)
  always_ff @(posedge CLK) begin
    if (nRST && accept) begin
      lb1[col_eff] <= mid;
      lb0[col_eff] <= PIX_IN;
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= top;
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= mid;
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= PIX_IN;
    end
  end

endmodule

// File: tb/tb_median_window_feeder.sv
// Testbench for median_window_feeder: frame-level reference model plus
// cycle-level expectations for DSI/PIX_READY timing.
module tb_median_window_feeder;

  localparam int WIDTH = 8;
  localparam int IMG_W = 4;

  logic             clk = 1'b0;
  logic             nrst;
  logic [WIDTH-1:0] pix_in;
  logic             pix_valid;
  logic             sof;
  logic             pix_ready;
  logic [WIDTH-1:0] di;
  logic             dsi;
  logic             dso;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [WIDTH-1:0] img_q [$];
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] cap_q [$];
  logic [WIDTH-1:0] want  [$];
  logic [WIDTH-1:0] src_pix [$];
  bit               src_sof [$];
  bit               busy      = 1'b0;
  int               send_left = 0;
  bit               exp_ready = 1'b0;
  bit               dsi_prev  = 1'b0;
  int               dsi_seen  = 0;
  int               wait_cnt  = 0;

  // Stimulus knobs
  int dso_delay  = 5;
  bit early_dso  = 1'b0;
  bit gaps       = 1'b0;
  int rst_target = 0;
  bit rst_pulse  = 1'b0;

  always #5 clk = ~clk;

  median_window_feeder #(
    .WIDTH(WIDTH),
    .IMG_W(IMG_W)
  ) dut (
    .CLK      (clk),
    .nRST     (nrst),
    .PIX_IN   (pix_in),
    .PIX_VALID(pix_valid),
    .SOF      (sof),
    .PIX_READY(pix_ready),
    .DI       (di),
    .DSI      (dsi),
    .DSO      (dso)
  );

  function automatic void model_reset();
    img_q.delete();
    exp_q.delete();
    busy      = 1'b0;
    send_left = 0;
  endfunction

  // Frame stored as a flat raster list; a window exists for every pixel
  // at row>=2, col>=2 of the current frame.
  function automatic bit model_accept(input logic [WIDTH-1:0] p, input bit s);
    int idx, r, c;
    if (s) img_q.delete();
    img_q.push_back(p);
    idx = img_q.size() - 1;
    r = idx / IMG_W;
    c = idx % IMG_W;
    if (r >= 2 && c >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          exp_q.push_back(img_q[(r - 2 + i) * IMG_W + (c - 2 + j)]);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock: predict the edge's effect, check outputs, drive next inputs.
  task automatic step();
    bit acc, take, rst, elig;
    logic [WIDTH-1:0] e;
    acc  = pix_valid && exp_ready && nrst;
    take = busy && (send_left == 0) && dso && nrst;
    rst  = !nrst;
    @(negedge clk);
    if (rst) begin
      model_reset();
      exp_ready = 1'b0;
    end else begin
      if (send_left > 0) send_left--;
      if (acc) begin
        elig = model_accept(pix_in, sof);
        void'(src_pix.pop_front());
        void'(src_sof.pop_front());
        if (elig) begin
          busy      = 1'b1;
          send_left = 9;
        end
      end
      if (take) busy = 1'b0;
      exp_ready = !busy;
    end

    vectors++;
    if (dsi !== (send_left > 0)) begin
      miscompares++;
      $display("FAIL dsi: got %b expected %b at %0t", dsi, (send_left > 0), $time);
    end
    vectors++;
    if (pix_ready !== exp_ready) begin
      miscompares++;
      $display("FAIL pix_ready: got %b expected %b at %0t", pix_ready, exp_ready, $time);
    end
    if (rst) begin
      vectors++;
      if (di !== '0) begin
        miscompares++;
        $display("FAIL di_reset: got %0d expected 0 at %0t", di, $time);
      end
    end
    if (dsi === 1'b1) begin
      dsi_seen++;
      if (!dsi_prev) cap_q.delete();
      cap_q.push_back(di);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL di_unexpected: got %0d expected no window at %0t", di, $time);
      end else begin
        e = exp_q.pop_front();
        if (di !== e) begin
          miscompares++;
          $display("FAIL di: got %0d expected %0d at %0t", di, e, $time);
        end
      end
    end
    dsi_prev = (dsi === 1'b1);

    // DSO responder: pulse dso_delay cycles into WAIT, optional stray pulse in SEND
    if (busy && send_left == 0) begin
      dso = (wait_cnt == dso_delay);
      wait_cnt++;
    end else begin
      wait_cnt = 0;
      dso = early_dso && (send_left == 4);
    end

    if (rst_pulse) begin
      nrst      = 1'b1;
      rst_pulse = 1'b0;
    end else if (rst_target > 0 && dsi === 1'b1 && dsi_seen == rst_target) begin
      nrst       = 1'b0;
      rst_pulse  = 1'b1;
      rst_target = 0;
    end

    if (src_pix.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
      pix_valid = 1'b1;
      pix_in    = src_pix[0];
      sof       = src_sof[0];
    end else begin
      pix_valid = 1'b0;
      pix_in    = WIDTH'($urandom);
      sof       = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run();
    int n;
    n = 0;
    while (!(src_pix.size() == 0 && !busy && nrst && !rst_pulse) && n < 2000) begin
      step();
      n++;
    end
    step();
    vectors++;
    if (n >= 2000) begin
      miscompares++;
      $display("FAIL run_timeout: stuck after %0d cycles, %0d pixels pending", n, src_pix.size());
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL windows_missing: %0d expected pixels never emitted, expected 0", exp_q.size());
    end
  endtask

  task automatic push_seq(input int first, input int count, input int sof_idx2);
    for (int i = 0; i < count; i++) begin
      src_pix.push_back(WIDTH'(first + i));
      src_sof.push_back(i == 0 || i == sof_idx2);
    end
  endtask

  task automatic check_cap(input string name);
    vectors++;
    if (cap_q.size() != 9) begin
      miscompares++;
      $display("FAIL %s_len: got %0d pixels expected 9", name, cap_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (cap_q[i] !== want[i]) begin
          miscompares++;
          $display("FAIL %s[%0d]: got %0d expected %0d", name, i, cap_q[i], want[i]);
          break;
        end
      end
    end
  endtask

  task automatic check_count(input string name, input int got, input int expct);
    vectors++;
    if (got != expct) begin
      miscompares++;
      $display("FAIL %s: got %0d DSI cycles expected %0d", name, got, expct);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    pix_valid = 1'b0;
    pix_in = '0;
    sof = 1'b0;
    dso = 1'b0;
    repeat (3) step();
    nrst = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_first_windows();
    int d0;
    d0 = dsi_seen;
    dso_delay = 5;
    gaps = 1'b0;
    early_dso = 1'b0;
    push_seq(1, 15, -1);
    run();
    check_count("first_windows_count", dsi_seen - d0, 27);
    want = '{8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
    check_cap("row_wrap_window");
  endtask

  task automatic test_early_dso();
    int d0;
    d0 = dsi_seen;
    early_dso = 1'b1;
    dso_delay = 3;
    for (int i = 0; i < 3 * IMG_W; i++) begin
      src_pix.push_back(WIDTH'($urandom));
      src_sof.push_back(i == 0);
    end
    run();
    early_dso = 1'b0;
    check_count("early_dso_count", dsi_seen - d0, 18);
  endtask

  task automatic test_reset_mid_send();
    int d0;
    d0 = dsi_seen;
    dso_delay = 2;
    rst_target = dsi_seen + 4;
    push_seq(1, 11, -1);
    run();
    check_count("aborted_window_count", dsi_seen - d0, 4);
    d0 = dsi_seen;
    push_seq(1, 11, -1);
    run();
    check_count("refeed_count", dsi_seen - d0, 9);
    want = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
    check_cap("refeed_window");
  endtask

  task automatic test_sof_restart();
    int d0;
    d0 = dsi_seen;
    dso_delay = 1;
    push_seq(100, 16, 5);
    run();
    check_count("sof_restart_count", dsi_seen - d0, 9);
    want = '{8'd105, 8'd106, 8'd107, 8'd109, 8'd110, 8'd111, 8'd113, 8'd114, 8'd115};
    check_cap("sof_restart_window");
  endtask

  task automatic test_random_frames();
    int d0, rows;
    gaps = 1'b1;
    for (int f = 0; f < 8; f++) begin
      d0 = dsi_seen;
      rows = int'($urandom_range(3, 6));
      dso_delay = int'($urandom_range(0, 6));
      early_dso = 1'($urandom_range(0, 1));
      for (int i = 0; i < rows * IMG_W; i++) begin
        src_pix.push_back(WIDTH'($urandom));
        src_sof.push_back(i == 0);
      end
      run();
      check_count("random_frame_count", dsi_seen - d0, 9 * (rows - 2) * (IMG_W - 2));
    end
    gaps = 1'b0;
    early_dso = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_windows();
    test_early_dso();
    test_reset_mid_send();
    test_sof_restart();
    test_random_frames();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/median_window_feeder.md
# median_window_feeder

Upstream neighbour of the 3x3 median stage. It accepts a raster pixel stream, holds the two previous image lines, and forms the 3x3 neighbourhood around each interior pixel. Each window goes out serially as 9 pixels on DI with DSI high. The block then stalls its input until the median stage reports completion on DSO.

## Interface
- WIDTH, 8, pixel bit width.
- IMG_W, 720, pixels per image line. Must be at least 3.
- CLK  in  1  clock. All logic is on the rising edge.
- nRST  in  1  reset, synchronous, active-low.
- PIX_IN  in  WIDTH  input pixel, raster order.
- PIX_VALID  in  1  PIX_IN is valid.
- SOF  in  1  marks the pixel at (row 0, col 0). Sampled only on an accepted pixel.
- PIX_READY  out  1  block can accept a pixel this cycle.
- DI  out  WIDTH  serialized window pixel to the median stage.
- DSI  out  1  DI valid; high for exactly 9 consecutive cycles per window.
- DSO  in  1  median stage result strobe; one-cycle pulse per window.

## Operation
- **Handshake.** A pixel is accepted when PIX_VALID and PIX_READY are both high in the same cycle. PIX_READY is high only in state ACCEPT and is low whenever nRST is low.
- **Counters.**
  - col counts 0..IMG_W-1 on each accept and wraps to 0.
  - row increments on each col wrap and saturates at 2.
  - An accept with SOF=1 is treated as (0,0): after it, col=1 and row=0.
- **Line buffers.** lb0 holds the previous line and lb1 the line before it. Each is IMG_W entries of WIDTH bits.
- **On each accept at column c:**
  - New window column = {top = lb1[c], mid = lb0[c], bot = PIX_IN}.
  - lb1[c] <= lb0[c]; lb0[c] <= PIX_IN.
- **Window.** 3x3 registers w[r][k], with r = 0..2 top to bottom and k = 0..2 left to right. On each accept the window shifts left by one column and the new column enters at k=2.
- **Eligibility.** A window is complete when the accepted pixel has row>=2 and col>=2, using the values before the counters update.
  - Only complete windows are emitted, so output is (H-2)x(W-2) per frame.
  - Line-buffer contents are never cleared; the eligibility rule masks stale data.
- **State machine.** Reset state is ACCEPT.
  - ACCEPT: go to SEND on a complete-window accept. Any other accept stays in ACCEPT.
  - SEND: k counts 0..8 and drives DI = w[k/3][k%3], i.e. row-major: top-left first, bottom-right last. After k=8, go to WAIT.
  - WAIT: on DSO=1, go to ACCEPT.
- **DSO outside WAIT.** DSO in ACCEPT or SEND is ignored and not remembered.
- **Widths.** col is clog2(IMG_W) bits. row is 2 bits. k is 4 bits. No arithmetic is performed on pixel data.

## Timing
- **Reset.** While nRST is low at a clock edge, the next state is:
  - state=ACCEPT, col=0, row=0, k=0, DSI=0, DI=0, PIX_READY=0.
  - Window registers and line buffers are not reset.
  - The first accept is possible in the cycle after the first edge with nRST high.
- **Output registers.** DI and DSI are registered.
  - Complete-window accept at edge t: DSI=1 from cycle t+1 through t+9.
  - DI = w[0][0] at t+1 and w[2][2] at t+9.
  - DSI=0 and DI holds its last value from t+10.
- **PIX_READY.**
  - Low from t+1 until DSO is seen.
  - DSO high at edge u in WAIT: PIX_READY=1 in cycle u+1.
  - Minimum window-to-window spacing is 11 cycles, assuming DSO arrives immediately.
- **Non-eligible accepts** (borders) sustain one pixel per cycle.
- **Reset mid-operation.** Reset during SEND or WAIT aborts the window: DSI=0 next cycle, and the counters restart at (0,0).
- **SOF mid-line.** Forces (0,0) regardless of current col/row. The window already being emitted is unaffected.
- **PIX_VALID without PIX_READY.** No state change; the source must hold PIX_IN.

## Test plan
- **First two windows.** IMG_W=4, 3 lines of pixels 1..12, SOF on pixel 1, DSO returned 5 cycles after DSI falls.
  - Pixels 1..10 are accepted back to back with DSI=0.
  - Pixel 11 gives DI = 1,2,3,5,6,7,9,10,11 on 9 consecutive DSI cycles.
  - Pixel 12, accepted after DSO, gives 2,3,4,6,7,8,10,11,12.
- **Stall behaviour.** PIX_VALID held high throughout the first-window test: PIX_READY stays 0 from the cycle after pixel 11 until the cycle after DSO. Pixel 12 is not lost or duplicated.
- **Row wrap.** Continue the first-window stream with pixels 13..16 (4th line).
  - Pixel 13 and pixel 14 each produce no window.
  - Pixel 15 gives 5,6,7,9,10,11,13,14,15.
- **Early DSO.** DSO pulsed during SEND: it is ignored, and the block still waits in WAIT for a later DSO.
- **Reset mid-SEND.** nRST low at the 4th DSI cycle.
  - Next cycle DSI=0 and PIX_READY=0; one cycle after release, PIX_READY=1.
  - Re-feeding 1..11 with SOF reproduces the first window exactly.
- **SOF restart.** SOF asserted mid-line (at pixel 6 of the stream): no window is emitted until 2 full lines plus 3 pixels of the new frame have been accepted.
